// File: rtl/kl8_console_pkg.sv
// Shared types and constants for the KL8 console host.
// State encodings, default ack timeout and the timeout-counter width helper.
package kl8_console_pkg;

    localparam int unsigned ACK_TIMEOUT_DEF = 255;

    typedef enum logic [1:0] {
        T_IDLE  = 2'd0,
        T_REQ   = 2'd1,
        T_DRAIN = 2'd2
    } tx_state_e;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_REQ  = 2'd1,
        R_CAPT = 2'd2
    } rx_state_e;

    // Counter must be able to hold the timeout value itself (it saturates there).
    function automatic int unsigned to_cnt_width(input int unsigned timeout);
        return $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/uart_req_chan.sv
// Generic req/ack issuer: raises req on start, drops it on ack or after ACK_TIMEOUT cycles.
// done/timeout are single-cycle combinational pulses in the last req cycle.
module uart_req_chan
    import kl8_console_pkg::*;
#(
    parameter int unsigned ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_start,
    input  logic i_ack,
    output logic o_req,
    output logic o_done_c,
    output logic o_timeout_c
);
    localparam int unsigned     CW   = to_cnt_width(ACK_TIMEOUT);
    localparam logic [CW-1:0]   LAST = CW'(ACK_TIMEOUT - 1);
    localparam logic [CW-1:0]   SAT  = CW'(ACK_TIMEOUT);

    logic          r_req;
    logic [CW-1:0] r_cnt;

    assign o_req       = r_req;
    assign o_done_c    = r_req & i_ack;
    assign o_timeout_c = r_req & ~i_ack & (r_cnt >= LAST);

    // r_cnt counts completed req cycles, so req stays high exactly ACK_TIMEOUT cycles.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_req <= 1'b0;
            r_cnt <= '0;
        end else if (i_start) begin
            r_req <= 1'b1;
            r_cnt <= '0;
        end else if (r_req) begin
            if (o_done_c || o_timeout_c) r_req <= 1'b0;
            if (r_cnt != SAT)            r_cnt <= r_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/kl8_console_host.sv
// KL8-style console host: TTO/TTI flags and data toward the IOT logic,
// req/ack initiator toward a UART responder, one character buffered each way.
module kl8_console_host
    import kl8_console_pkg::*;
#(
    parameter int unsigned ACK_TIMEOUT = ACK_TIMEOUT_DEF,
    parameter bit          RX_POLL     = 1'b1
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_tto_wr,
    input  logic [7:0] i_tto_data,
    input  logic       i_tto_clr,
    output logic       o_tto_flag,
    output logic       o_tto_busy,
    input  logic       i_tti_fetch,
    input  logic       i_tti_clr,
    output logic       o_tti_flag,
    output logic [7:0] o_tti_data,
    input  logic       i_ie_wr,
    input  logic       i_ie_in,
    output logic       o_irq,
    input  logic       i_err_clr,
    output logic       o_tx_err,
    output logic       o_rx_err,
    output logic       o_tx_req,
    output logic [7:0] o_tx_data,
    input  logic       i_tx_ack,
    input  logic       i_tx_empty,
    output logic       o_rx_req,
    input  logic       i_rx_ack,
    input  logic       i_rx_empty,
    input  logic [7:0] i_rx_data
);
    tx_state_e  r_tx_state, w_tx_nxt;
    rx_state_e  r_rx_state, w_rx_nxt;
    logic       r_pend, w_pend_nxt;
    logic       r_drain_first, w_drain_nxt;
    logic [7:0] r_tx_data, w_tx_data_nxt;
    logic [7:0] r_tti_data, w_tti_data_nxt;
    logic       r_tto_flag, w_tto_flag_nxt;
    logic       r_tto_busy;
    logic       r_tti_flag, w_tti_flag_nxt;
    logic       r_fetch, w_fetch_nxt;
    logic       r_ie, w_ie_nxt;
    logic       r_irq;
    logic       r_tx_err, w_tx_err_nxt;
    logic       r_rx_err, w_rx_err_nxt;

    logic w_tx_start, w_tx_done, w_tx_to;
    logic w_rx_start, w_rx_done, w_rx_to;
    logic w_accept, w_tto_set, w_tto_load, w_tx_err_set;
    logic w_tti_held, w_tti_set, w_rx_err_set;

    uart_req_chan #(.ACK_TIMEOUT(ACK_TIMEOUT)) u_tx_chan (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_start     (w_tx_start),
        .i_ack       (i_tx_ack),
        .o_req       (o_tx_req),
        .o_done_c    (w_tx_done),
        .o_timeout_c (w_tx_to)
    );

    uart_req_chan #(.ACK_TIMEOUT(ACK_TIMEOUT)) u_rx_chan (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_start     (w_rx_start),
        .i_ack       (i_rx_ack),
        .o_req       (o_rx_req),
        .o_done_c    (w_rx_done),
        .o_timeout_c (w_rx_to)
    );

    // TX next-state: a write while the UART is busy is parked in r_pend.
    always_comb begin
        w_tx_nxt      = r_tx_state;
        w_pend_nxt    = r_pend;
        w_drain_nxt   = r_drain_first;
        w_tx_data_nxt = r_tx_data;
        w_tx_start    = 1'b0;
        w_tto_set     = 1'b0;
        w_tto_load    = 1'b0;
        w_tx_err_set  = 1'b0;
        w_accept      = i_tto_wr & ~r_tto_busy;
        case (r_tx_state)
            T_IDLE: begin
                if (w_accept) begin
                    w_tx_data_nxt = i_tto_data;
                    w_tto_load    = 1'b1;
                    if (i_tx_empty) begin
                        w_tx_start = 1'b1;
                        w_tx_nxt   = T_REQ;
                    end else begin
                        w_pend_nxt = 1'b1;
                    end
                end else if (r_pend && i_tx_empty) begin
                    w_tx_start = 1'b1;
                    w_pend_nxt = 1'b0;
                    w_tx_nxt   = T_REQ;
                end
            end
            T_REQ: begin
                if (w_tx_done) begin
                    w_drain_nxt = 1'b1;
                    w_tx_nxt    = T_DRAIN;
                end else if (w_tx_to) begin
                    w_tx_err_set = 1'b1;
                    w_tto_set    = 1'b1;
                    w_tx_nxt     = T_IDLE;
                end
            end
            T_DRAIN: begin
                // Responder drops tx_empty only on the edge after ack; skip that cycle.
                if (r_drain_first) begin
                    w_drain_nxt = 1'b0;
                end else if (i_tx_empty) begin
                    w_tto_set = 1'b1;
                    w_tx_nxt  = T_IDLE;
                end
            end
            default: w_tx_nxt = T_IDLE;
        endcase
        w_tto_flag_nxt = w_tto_set | (r_tto_flag & ~i_tto_clr & ~w_tto_load);
        w_tx_err_nxt   = w_tx_err_set | (r_tx_err & ~i_err_clr);
    end

    // RX next-state: a pending tti_clr frees the buffer in time to start this cycle.
    always_comb begin
        w_rx_nxt       = r_rx_state;
        w_tti_data_nxt = r_tti_data;
        w_rx_start     = 1'b0;
        w_tti_set      = 1'b0;
        w_rx_err_set   = 1'b0;
        w_fetch_nxt    = r_fetch | i_tti_fetch;
        w_tti_held     = r_tti_flag & ~i_tti_clr;
        case (r_rx_state)
            R_IDLE: begin
                if (!i_rx_empty && !w_tti_held && (RX_POLL || w_fetch_nxt)) begin
                    w_rx_start  = 1'b1;
                    w_fetch_nxt = 1'b0;
                    w_rx_nxt    = R_REQ;
                end
            end
            R_REQ: begin
                if (w_rx_done) begin
                    w_rx_nxt = R_CAPT;
                end else if (w_rx_to) begin
                    w_rx_err_set = 1'b1;
                    w_rx_nxt     = R_IDLE;
                end
            end
            R_CAPT: begin
                w_tti_data_nxt = i_rx_data;
                w_tti_set      = 1'b1;
                w_rx_nxt       = R_IDLE;
            end
            default: w_rx_nxt = R_IDLE;
        endcase
        w_tti_flag_nxt = w_tti_set | w_tti_held;
        w_rx_err_nxt   = w_rx_err_set | (r_rx_err & ~i_err_clr);
        w_ie_nxt       = i_ie_wr ? i_ie_in : r_ie;
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_tx_state    <= T_IDLE;
            r_rx_state    <= R_IDLE;
            r_pend        <= 1'b0;
            r_drain_first <= 1'b0;
            r_tx_data     <= '0;
            r_tti_data    <= '0;
            r_tto_flag    <= 1'b0;
            r_tto_busy    <= 1'b0;
            r_tti_flag    <= 1'b0;
            r_fetch       <= 1'b0;
            r_ie          <= 1'b0;
            r_irq         <= 1'b0;
            r_tx_err      <= 1'b0;
            r_rx_err      <= 1'b0;
        end else begin
            r_tx_state    <= w_tx_nxt;
            r_rx_state    <= w_rx_nxt;
            r_pend        <= w_pend_nxt;
            r_drain_first <= w_drain_nxt;
            r_tx_data     <= w_tx_data_nxt;
            r_tti_data    <= w_tti_data_nxt;
            r_tto_flag    <= w_tto_flag_nxt;
            r_tto_busy    <= (w_tx_nxt != T_IDLE) | w_pend_nxt;
            r_tti_flag    <= w_tti_flag_nxt;
            r_fetch       <= w_fetch_nxt;
            r_ie          <= w_ie_nxt;
            r_irq         <= w_ie_nxt & (w_tti_flag_nxt | w_tto_flag_nxt);
            r_tx_err      <= w_tx_err_nxt;
            r_rx_err      <= w_rx_err_nxt;
        end
    end

    assign o_tto_flag = r_tto_flag;
    assign o_tto_busy = r_tto_busy;
    assign o_tti_flag = r_tti_flag;
    assign o_tti_data = r_tti_data;
    assign o_irq      = r_irq;
    assign o_tx_err   = r_tx_err;
    assign o_rx_err   = r_rx_err;
    assign o_tx_data  = r_tx_data;

endmodule

// File: tb/tb_kl8_console_host.sv
// Directed bench for kl8_console_host with a hand-driven UART responder.
module tb_kl8_console_host;

    logic       clk;
    logic       rst_n;
    logic       tto_wr, tto_clr, tti_fetch, tti_clr, ie_wr, ie_in, err_clr;
    logic [7:0] tto_data, rx_data;
    logic       tx_ack, tx_empty, rx_ack, rx_empty;
    logic       tto_flag, tto_busy, tti_flag, irq, tx_err, rx_err, tx_req, rx_req;
    logic [7:0] tti_data, tx_data;

    int n_checks = 0;
    int n_fail   = 0;

    kl8_console_host #(.ACK_TIMEOUT(4), .RX_POLL(1'b1)) dut (
        .i_clk       (clk),
        .i_reset     (rst_n),
        .i_tto_wr    (tto_wr),
        .i_tto_data  (tto_data),
        .i_tto_clr   (tto_clr),
        .o_tto_flag  (tto_flag),
        .o_tto_busy  (tto_busy),
        .i_tti_fetch (tti_fetch),
        .i_tti_clr   (tti_clr),
        .o_tti_flag  (tti_flag),
        .o_tti_data  (tti_data),
        .i_ie_wr     (ie_wr),
        .i_ie_in     (ie_in),
        .o_irq       (irq),
        .i_err_clr   (err_clr),
        .o_tx_err    (tx_err),
        .o_rx_err    (rx_err),
        .o_tx_req    (tx_req),
        .o_tx_data   (tx_data),
        .i_tx_ack    (tx_ack),
        .i_tx_empty  (tx_empty),
        .o_rx_req    (rx_req),
        .i_rx_ack    (rx_ack),
        .i_rx_empty  (rx_empty),
        .i_rx_data   (rx_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs set before tick() are sampled at its edge; outputs are read 1 ns after.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] msg [6];
    logic       seen;
    int         cnt;
    int         pulses;

    initial begin
        msg[0] = 8'h53; msg[1] = 8'h54; msg[2] = 8'h41;
        msg[3] = 8'h52; msg[4] = 8'h54; msg[5] = 8'h0D;
        rst_n = 1'b0;
        tto_wr = 0; tto_clr = 0; tti_fetch = 0; tti_clr = 0;
        ie_wr = 0; ie_in = 0; err_clr = 0;
        tto_data = 8'h00; rx_data = 8'h00;
        tx_ack = 0; tx_empty = 1; rx_ack = 0; rx_empty = 1;
        tick(); tick();
        check("rst_tx_req", tx_req, 0);
        check("rst_rx_req", rx_req, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_tti_data", tti_data, 0);
        check("rst_flags", {tto_flag, tti_flag, tto_busy, irq, tx_err, rx_err}, 0);
        rst_n = 1'b1;
        tick();

        // Reset in the middle of a TX request
        tto_wr = 1; tto_data = 8'h53;
        tick();
        tto_wr = 0;
        check("t1_tx_req", tx_req, 1);
        check("t1_tx_data", tx_data, 8'h53);
        tick();
        rst_n = 1'b0;
        #1;
        check("t1_async_req", tx_req, 0);
        check("t1_async_state", {tx_data, tto_busy, tto_flag}, 0);
        tick(); tick();
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            seen |= tx_req | rx_req;
        end
        check("t1_no_cleanup_req", seen, 0);

        // Normal transmit with interrupts enabled
        ie_wr = 1; ie_in = 1;
        tick();
        ie_wr = 0;
        check("t2_irq_idle", irq, 0);
        tto_wr = 1; tto_data = 8'h41;
        tick();
        tto_wr = 0;
        check("t2_tx_req", tx_req, 1);
        check("t2_tx_data", tx_data, 8'h41);
        tx_ack = 1;
        tick();
        tx_ack = 0; tx_empty = 0;
        check("t2_req_drop", tx_req, 0);
        check("t2_busy", tto_busy, 1);
        for (int i = 0; i < 20; i++) tick();
        check("t2_flag_wait", tto_flag, 0);
        tx_empty = 1;
        tick();
        check("t2_flag", tto_flag, 1);
        check("t2_irq", irq, 1);
        check("t2_busy_end", tto_busy, 0);
        tto_clr = 1;
        tick();
        tto_clr = 0;
        check("t2_clr", {tto_flag, irq}, 0);

        // Receive "START\r" with polling
        rx_empty = 0;
        tick();
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            check("t3_rx_req", rx_req, 1);
            rx_ack = 1;
            tick();
            rx_ack = 0; rx_data = msg[i];
            if (i == 5) rx_empty = 1;
            tick();
            check("t3_tti_data", tti_data, msg[i]);
            if (tti_flag) pulses++;
            tti_clr = 1;
            tick();
            tti_clr = 0;
        end
        check("t3_pulses", pulses, 6);
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            seen |= rx_req;
        end
        check("t3_rx_idle", {seen, tti_flag}, 0);

        // Back-pressure: a held TTI flag blocks the next fetch
        rx_empty = 0;
        tick();
        check("t4_rx_req", rx_req, 1);
        rx_ack = 1;
        tick();
        rx_ack = 0; rx_data = 8'h31;
        tick();
        check("t4_flag", {tti_flag, tti_data}, {1'b1, 8'h31});
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            seen |= rx_req;
        end
        check("t4_blocked", seen, 0);
        tti_clr = 1;
        tick();
        tti_clr = 0;
        check("t4_resume", rx_req, 1);
        rx_ack = 1;
        tick();
        rx_ack = 0; rx_data = 8'h32; rx_empty = 1;
        tick();
        check("t4_data2", tti_data, 8'h32);
        tti_clr = 1;
        tick();
        tti_clr = 0;
        tto_clr = 1; ie_wr = 1; ie_in = 0;
        tick();
        tto_clr = 0; ie_wr = 0;

        // TX ack timeout
        tto_wr = 1; tto_data = 8'h58;
        tick();
        tto_wr = 0;
        cnt = 0;
        for (int i = 0; i < 10 && tx_req; i++) begin
            cnt++;
            tick();
        end
        check("t5_req_cycles", cnt, 4);
        check("t5_tx_err", tx_err, 1);
        check("t5_tto_flag", tto_flag, 1);
        check("t5_busy", tto_busy, 0);
        err_clr = 1;
        tick();
        err_clr = 0;
        check("t5_err_clr", tx_err, 0);
        tto_clr = 1;
        tick();
        tto_clr = 0;

        // RX ack timeout
        rx_empty = 0;
        tick();
        rx_empty = 1;
        cnt = 0;
        for (int i = 0; i < 10 && rx_req; i++) begin
            cnt++;
            tick();
        end
        check("t5_rx_cycles", cnt, 4);
        check("t5_rx_err", {rx_err, tti_flag}, 2'b10);
        err_clr = 1;
        tick();
        err_clr = 0;
        check("t5_rx_err_clr", rx_err, 0);

        // Spurious ack while idle
        tx_ack = 1; rx_ack = 1;
        tick();
        tx_ack = 0; rx_ack = 0;
        check("t6_spurious", {tx_req, rx_req, tto_busy, tti_flag}, 0);

        // tto_clr coincident with flag set: set wins
        tto_wr = 1; tto_data = 8'h59;
        tick();
        tto_wr = 0; tx_ack = 1;
        tick();
        tx_ack = 0; tx_empty = 0;
        tick(); tick();
        tx_empty = 1; tto_clr = 1;
        tick();
        tto_clr = 0;
        check("t6_set_wins", tto_flag, 1);

        // Write while UART busy is held, then issued when tx_empty rises
        tx_empty = 0; tto_wr = 1; tto_data = 8'h5A;
        tick();
        tto_wr = 0;
        check("t6_pend", {tx_req, tto_busy}, 2'b01);
        tto_wr = 1; tto_data = 8'h41;
        tick();
        tto_wr = 0;
        tick(); tick();
        check("t6_drop", {tx_req, tx_data}, {1'b0, 8'h5A});
        tx_empty = 1;
        tick();
        check("t6_pend_issue", {tx_req, tx_data}, {1'b1, 8'h5A});
        tx_ack = 1;
        tick();
        tx_ack = 0; tx_empty = 0;
        tick();
        tx_empty = 1;
        tick();
        check("t6_pend_done", {tto_flag, tto_busy, tx_err}, 3'b100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
